// File: rtl/prog_loader.sv
// Boot-time program loader: packs a UART byte stream into 32-bit instruction words,
// writes them from address 0, then releases the CPU via cpu_run.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_SIZE   = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  output logic                  cpu_run,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  localparam logic [15:0] MEM_SIZE_W = 16'(MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_WORD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_IMAGE = S_CHK;
`else
  localparam state_t S_AFTER_IMAGE = S_DONE;
`endif

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_q, word_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  cpu_run_q, cpu_run_d;
  logic                  load_err_q, load_err_d;
  logic [15:0]           words_loaded_q, words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q, xor_d;
`endif

  logic [15:0] full_cnt;
  logic [31:0] word_full;
  logic        last_word;

  assign full_cnt  = {count_q[15:8], rx_data};
  assign word_full = {word_q, rx_data};
  assign last_word = (words_loaded_q + 16'd1) == count_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d        = state_q;
    count_d        = count_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    mem_we_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_run_d      = cpu_run_q;
    load_err_d     = load_err_q;
    words_loaded_d = words_loaded_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d          = xor_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          count_d[15:8] = rx_data;
          state_d       = S_CNT_LO;
`ifdef LOADER_CHECKSUM_EN
          xor_d         = 8'h00;
`endif
        end
      end
      S_CNT_LO: begin
        if (rx_valid) begin
          count_d    = full_cnt;
          byte_idx_d = 2'd0;
          if (full_cnt > MEM_SIZE_W)  state_d = S_ERR;
          else if (full_cnt == 16'd0) state_d = S_AFTER_IMAGE;
          else                        state_d = S_WORD;
        end
      end
      S_WORD: begin
        if (rx_valid) begin
          word_d     = word_full[23:0];
          byte_idx_d = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ rx_data;
`endif
          if (byte_idx_q == 2'd3) begin
            // Address is the pre-increment count, so word k lands at address k.
            mem_we_d       = 1'b1;
            mem_addr_d     = words_loaded_q[ADDR_WIDTH-1:0];
            mem_wdata_d    = word_full;
            words_loaded_d = words_loaded_q + 16'd1;
            if (last_word) state_d = S_AFTER_IMAGE;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        // cpu_run follows the state by one cycle, so the last write lands first.
        if (reload) begin
          state_d        = S_IDLE;
          cpu_run_d      = 1'b0;
          load_err_d     = 1'b0;
          words_loaded_d = 16'd0;
        end else begin
          cpu_run_d = 1'b1;
        end
      end
      S_ERR: begin
        if (reload) begin
          state_d        = S_IDLE;
          cpu_run_d      = 1'b0;
          load_err_d     = 1'b0;
          words_loaded_d = 16'd0;
        end else begin
          load_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_run_q      <= 1'b0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_run_q      <= cpu_run_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

endmodule
